// File: rtl/bsg_manycore_stat_tag_tracker_pkg.sv
// Shared types for the stat tag tracker: tag field layout, record layout
// and error bit positions.
package bsg_manycore_stat_pkg;

  localparam int STAT_TAG_W     = 32;
  localparam int STAT_TILE_W    = 14;
  localparam int STAT_ID_W      = 16;
  localparam int STAT_CTR_MAX_W = 32;

  typedef enum logic [1:0] {
    SNAPSHOT = 2'b00,
    START    = 2'b01,
    END      = 2'b10,
    RSVD     = 2'b11
  } stat_kind_e;

  typedef struct packed {
    stat_kind_e             kind;
    logic [STAT_TILE_W-1:0] tile;
    logic [STAT_ID_W-1:0]   id;
  } stat_tag_s;

  // elapsed is always STAT_CTR_MAX_W wide; narrower counters are zero-extended
  typedef struct packed {
    stat_kind_e                kind;
    logic [STAT_TILE_W-1:0]    tile;
    logic [STAT_ID_W-1:0]      id;
    logic [STAT_CTR_MAX_W-1:0] elapsed;
  } stat_rec_s;

  localparam int ERR_UNMATCHED_END = 0;
  localparam int ERR_DOUBLE_START  = 1;
  localparam int ERR_BAD_ID        = 2;
  localparam int ERR_OVERFLOW      = 3;

endpackage

// File: rtl/bsg_manycore_stat_tag_tracker_fifo.sv
// Small circular record queue. A write while full is accepted when the
// head is consumed in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CNT_W = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_enq;
  logic               w_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(els_p));
  assign v_o     = (r_count != '0);
  assign ready_o = !w_full || yumi_i;
  assign w_enq   = v_i && ready_o;
  assign w_deq   = yumi_i && v_o;
  assign data_o  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since r_count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_stat_tag_tracker.sv
// Pairs START/END print_stat tags per id, measures elapsed cycles and queues
// completed records on a valid/yumi stream. Sticky protocol error flags.
// Optional trace/assertions: define BSG_STAT_TAG_TRACKER_TRACE_EN.
module bsg_manycore_stat_tag_tracker
  import bsg_manycore_stat_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int num_tags_p   = 16,
  parameter int ctr_width_p  = 32,
  parameter int fifo_els_p   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          print_stat_v_i,
  input  logic [data_width_p-1:0]       print_stat_tag_i,
  output logic                          rec_v_o,
  output stat_rec_s                     rec_o,
  input  logic                          rec_yumi_i,
  output logic [$clog2(num_tags_p):0]   open_count_o,
  output logic [3:0]                    err_o,
  output logic [ctr_width_p-1:0]        cycle_o
);

  localparam int IDX_W = $clog2(num_tags_p);
  localparam int OCNT_W = IDX_W + 1;
  localparam logic [STAT_ID_W:0] NUM_TAGS_L = (STAT_ID_W + 1)'(num_tags_p);

  logic [ctr_width_p-1:0] r_cycle;
  logic [num_tags_p-1:0]  r_open;
  logic [ctr_width_p-1:0] r_start [num_tags_p];
  logic [OCNT_W-1:0]      r_open_cnt;
  logic [3:0]             r_err;

  stat_tag_s              w_tag;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_bad;
  logic                   w_is_open;
  logic                   w_start;
  logic                   w_end_ok;
  logic                   w_enq_v;
  logic [ctr_width_p-1:0] w_elapsed;
  stat_rec_s              w_rec;
  logic                   w_fifo_ready;
  logic [3:0]             w_err_set;

  assign w_tag     = stat_tag_s'(print_stat_tag_i[STAT_TAG_W-1:0]);
  assign w_idx     = w_tag.id[IDX_W-1:0];
  assign w_bad     = (w_tag.kind == RSVD) || ({1'b0, w_tag.id} >= NUM_TAGS_L);
  assign w_is_open = r_open[w_idx];
  assign w_start   = print_stat_v_i && !w_bad && (w_tag.kind == START);
  assign w_end_ok  = print_stat_v_i && !w_bad && (w_tag.kind == END) && w_is_open;
  assign w_enq_v   = w_end_ok || (print_stat_v_i && !w_bad && (w_tag.kind == SNAPSHOT));

  // Modular subtraction gives the right delta across counter wrap
  assign w_elapsed = (w_tag.kind == END) ? (r_cycle - r_start[w_idx]) : r_cycle;

  assign w_rec.kind    = w_tag.kind;
  assign w_rec.tile    = w_tag.tile;
  assign w_rec.id      = w_tag.id;
  assign w_rec.elapsed = STAT_CTR_MAX_W'(w_elapsed);

  // Error events raised this cycle; several may coincide
  always_comb begin
    w_err_set = '0;
    w_err_set[ERR_UNMATCHED_END] = print_stat_v_i && !w_bad && (w_tag.kind == END) && !w_is_open;
    w_err_set[ERR_DOUBLE_START]  = w_start && w_is_open;
    w_err_set[ERR_BAD_ID]        = print_stat_v_i && w_bad;
    w_err_set[ERR_OVERFLOW]      = w_enq_v && !w_fifo_ready;
  end

  // Cycle counter, open table, open count and sticky errors
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cycle    <= '0;
      r_open     <= '0;
      r_open_cnt <= '0;
      r_err      <= '0;
    end else begin
      r_cycle <= r_cycle + ctr_width_p'(1);
      r_err   <= r_err | w_err_set;
      if (w_start) begin
        r_open[w_idx] <= 1'b1;
        if (!w_is_open) r_open_cnt <= r_open_cnt + OCNT_W'(1);
      end
      if (w_end_ok) begin
        r_open[w_idx] <= 1'b0;
        r_open_cnt    <= r_open_cnt - OCNT_W'(1);
      end
    end
  end

  // Start timestamps; validity is tracked by r_open, so no reset needed
  always_ff @(posedge clk_i) begin
    if (w_start) r_start[w_idx] <= r_cycle;
  end

  bsg_fifo_1r1w_small #(
    .width_p ($bits(stat_rec_s)),
    .els_p   (fifo_els_p)
  ) u_rec_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_enq_v),
    .ready_o (w_fifo_ready),
    .data_i  (w_rec),
    .v_o     (rec_v_o),
    .data_o  (rec_o),
    .yumi_i  (rec_yumi_i)
  );

  assign open_count_o = r_open_cnt;
  assign err_o        = r_err;
  assign cycle_o      = r_cycle;

`ifdef BSG_STAT_TAG_TRACKER_TRACE_EN
  // Simulation trace of enqueues and error rises, plus handshake check
  always @(posedge clk_i) begin
    if (!reset_i && w_enq_v && w_fifo_ready)
      $display("[STAT] t=%0d kind=%0d tile=%0h id=%0d elapsed=%0d",
               r_cycle, w_rec.kind, w_rec.tile, w_rec.id, w_rec.elapsed);
    if (!reset_i && |(w_err_set & ~r_err))
      $display("[STAT] t=%0d err rise %b", r_cycle, w_err_set & ~r_err);
    if (!reset_i && rec_yumi_i && !rec_v_o)
      $error("[STAT] rec_yumi_i asserted without rec_v_o");
  end
`else
  // Untraced build: identical datapath, no simulation-only checks.
`endif

endmodule

// File: tb/tb_bsg_manycore_stat_tag_tracker.sv
// Randomized + directed bench for bsg_manycore_stat_tag_tracker with a
// scoreboard queue and an independent record monitor.
module tb_bsg_manycore_stat_tag_tracker;
  import bsg_manycore_stat_pkg::*;

  localparam int NT = 16;
  localparam int FE = 4;

  logic        clk = 0;
  logic        reset_i = 1;
  logic        v_i = 0;
  logic [31:0] tag_i = '0;
  logic        yumi_i = 0;
  logic        rec_v;
  stat_rec_s   rec;
  logic [4:0]  open_cnt;
  logic [3:0]  err;
  logic [31:0] cyc;

  logic        r8 = 1;
  logic        v8 = 0;
  logic [31:0] tag8 = '0;
  logic        yumi8 = 0;
  logic        rec_v8;
  stat_rec_s   rec8;
  logic [4:0]  open_cnt8;
  logic [3:0]  err8;
  logic [7:0]  cyc8;

  always #5 clk = ~clk;

  bsg_manycore_stat_tag_tracker #(.data_width_p(32), .num_tags_p(NT), .ctr_width_p(32), .fifo_els_p(FE)) dut (
    .clk_i(clk), .reset_i(reset_i), .print_stat_v_i(v_i), .print_stat_tag_i(tag_i),
    .rec_v_o(rec_v), .rec_o(rec), .rec_yumi_i(yumi_i),
    .open_count_o(open_cnt), .err_o(err), .cycle_o(cyc));

  bsg_manycore_stat_tag_tracker #(.data_width_p(32), .num_tags_p(NT), .ctr_width_p(8), .fifo_els_p(FE)) dut8 (
    .clk_i(clk), .reset_i(r8), .print_stat_v_i(v8), .print_stat_tag_i(tag8),
    .rec_v_o(rec_v8), .rec_o(rec8), .rec_yumi_i(yumi8),
    .open_count_o(open_cnt8), .err_o(err8), .cycle_o(cyc8));

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  // reference model state
  logic [63:0]     sb[$];
  bit              open_m [NT];
  int unsigned     start_m [NT];
  int unsigned     cyc_m;
  int              open_cnt_m;
  int              occ_m;
  logic [3:0]      err_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every consumed record against the scoreboard head,
  // and require a held record to stay stable.
  logic [63:0] prev_rec;
  bit          prev_hold = 0;
  always @(negedge clk) begin
    if (reset_i) begin
      prev_hold = 0;
    end else begin
      if (prev_hold && rec_v) chk("rec_stable", rec, prev_rec);
      if (rec_v && yumi_i) begin
        if (sb.size() == 0) chk("rec_unexpected", rec, 64'hx);
        else chk("rec", rec, sb.pop_front());
        n_pop++;
      end
      prev_hold = rec_v && !yumi_i;
      prev_rec  = rec;
    end
  end

  task automatic do_reset();
    reset_i = 1; v_i = 0; yumi_i = 0;
    @(posedge clk); #1;
    reset_i = 0;
    sb.delete();
    for (int i = 0; i < NT; i++) begin open_m[i] = 0; start_m[i] = 0; end
    cyc_m = 0; open_cnt_m = 0; occ_m = 0; err_m = '0;
    chk("rst_rec_v", 64'(rec_v), 64'd0);
    chk("rst_open", 64'(open_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cycle", 64'(cyc), 64'd0);
  endtask

  // One clock of stimulus with the model applied from the rules directly
  task automatic step(input bit v, input logic [1:0] kind, input logic [13:0] tile,
                      input int id, input bit yumi);
    bit          enq;
    bit          yeff;
    int unsigned el;
    enq = 0; el = 0;
    yeff = yumi && rec_v;
    chk("cycle", 64'(cyc), 64'(cyc_m));
    v_i = v; tag_i = {kind, tile, 16'(id)}; yumi_i = yeff;
    if (v) begin
      if (kind == 2'b11 || id >= NT) err_m[2] = 1;
      else if (kind == 2'b00) begin enq = 1; el = cyc_m; end
      else if (kind == 2'b01) begin
        if (open_m[id]) err_m[1] = 1; else open_cnt_m++;
        open_m[id] = 1; start_m[id] = cyc_m;
      end else begin
        if (open_m[id]) begin
          enq = 1; el = cyc_m - start_m[id]; open_m[id] = 0; open_cnt_m--;
        end else err_m[0] = 1;
      end
    end
    if (enq) begin
      if (occ_m == FE && !yeff) err_m[3] = 1;
      else begin sb.push_back({kind, tile, 16'(id), el}); occ_m++; end
    end
    if (yeff) occ_m--;
    @(posedge clk); #1;
    cyc_m++;
    v_i = 0; yumi_i = 0;
    chk("err", 64'(err), 64'(err_m));
    chk("open_count", 64'(open_cnt), 64'(open_cnt_m));
  endtask

  task automatic idle_to(input int unsigned target);
    while (cyc_m < target) step(0, 2'b00, 14'h0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && occ_m > 0; i++) step(0, 2'b00, 14'h0, 0, 1);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_rec_v", 64'(rec_v), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // 1: START id3 @10, END id3 @110
    do_reset();
    idle_to(10);
    step(1, 2'b01, 14'h12, 3, 0);
    chk("t1_open1", 64'(open_cnt), 64'd1);
    idle_to(110);
    step(1, 2'b10, 14'h12, 3, 0);
    chk("t1_rec_v", 64'(rec_v), 64'd1);
    chk("t1_elapsed", 64'(rec.elapsed), 64'd100);
    chk("t1_id", 64'(rec.id), 64'd3);
    chk("t1_open0", 64'(open_cnt), 64'd0);
    drain();

    // 2: unmatched END
    do_reset();
    step(1, 2'b10, 14'h0, 5, 0);
    step(0, 2'b00, 14'h0, 0, 0);
    chk("t2_err", 64'(err), 64'b0001);
    chk("t2_rec_v", 64'(rec_v), 64'd0);

    // 3: double START
    do_reset();
    idle_to(20); step(1, 2'b01, 14'h3, 1, 0);
    idle_to(30); step(1, 2'b01, 14'h3, 1, 0);
    idle_to(50); step(1, 2'b10, 14'h3, 1, 0);
    chk("t3_err", 64'(err), 64'b0010);
    chk("t3_elapsed", 64'(rec.elapsed), 64'd20);
    drain();

    // 4a: overflow with no consumer
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 5; i++) step(1, 2'b00, 14'(i), i, 0);
    chk("t4a_err", 64'(err), 64'b1000);
    drain();
    chk("t4a_pops", 64'(n_pop - p0), 64'd4);

    // 4b: consume on the cycle the fifth arrives while full
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 4; i++) step(1, 2'b00, 14'(i), i, 0);
    step(1, 2'b00, 14'h4, 4, 1);
    chk("t4b_err", 64'(err), 64'b0000);
    drain();
    chk("t4b_pops", 64'(n_pop - p0), 64'd5);

    // 6: reserved kind, out-of-range id, reset discards open tags
    do_reset();
    step(1, 2'b11, 14'h0, 1, 0);
    chk("t6_rsvd", 64'(err), 64'b0100);
    do_reset();
    step(1, 2'b01, 14'h0, NT, 0);
    chk("t6_badid", 64'(err), 64'b0100);
    chk("t6_badid_open", 64'(open_cnt), 64'd0);
    step(1, 2'b01, 14'h0, 2, 0);
    step(1, 2'b00, 14'h0, 7, 0);
    do_reset();
    step(1, 2'b10, 14'h0, 2, 0);
    chk("t6_after_rst_err", 64'(err), 64'b0001);
    chk("t6_after_rst_rec", 64'(rec_v), 64'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r; int id; logic [1:0] k;
      r  = int'($urandom_range(0, 19));
      k  = (r < 4) ? 2'b00 : (r < 11) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      id = ($urandom_range(0, 24) == 0) ? NT + int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, k, 14'($urandom), id, $urandom_range(0, 1) == 1);
    end
    drain();

    // 5: 8-bit counter wrap
    r8 = 1; @(posedge clk); #1; r8 = 0;
    repeat (250) @(posedge clk);
    #1;
    chk("t5_cycle250", 64'(cyc8), 64'd250);
    v8 = 1; tag8 = {2'b01, 14'h0, 16'd0};
    @(posedge clk); #1; v8 = 0;
    chk("t5_open", 64'(open_cnt8), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("t5_cycle260", 64'(cyc8), 64'd4);
    v8 = 1; tag8 = {2'b10, 14'h0, 16'd0};
    @(posedge clk); #1; v8 = 0;
    chk("t5_rec_v", 64'(rec_v8), 64'd1);
    chk("t5_elapsed", 64'(rec8.elapsed), 64'd10);
    chk("t5_err", 64'(err8), 64'd0);
    yumi8 = 1; @(posedge clk); #1; yumi8 = 0;
    chk("t5_rec_v_after", 64'(rec_v8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
